// File: rtl/ga20_sample_fetch_if.sv
// GA20 sample-fetch bus: the GA20 sample read port plus the memory arbiter
// req/ack port. The slave modport is the fetch unit; the master modport drives both sides.
interface ga20_sample_fetch_if #(
    parameter int MEM_AW = 24
);
    logic              sample_rd;
    logic [19:0]       sample_addr;
    logic              sample_valid;
    logic [7:0]        sample_din;
    logic              mem_req;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_ack;
    logic [15:0]       mem_data;

    modport slave (
        input  sample_rd, sample_addr, mem_ack, mem_data,
        output sample_valid, sample_din, mem_req, mem_addr
    );

    modport master (
        output sample_rd, sample_addr, mem_ack, mem_data,
        input  sample_valid, sample_din, mem_req, mem_addr
    );
endinterface

// File: rtl/ga20_sample_fetch.sv
// GA20 sample-ROM responder: byte reads served from 16-bit memory words via req/ack.
// Define GA20_FETCH_CACHE_EN to add the direct-mapped word cache; otherwise every read fetches.
module ga20_sample_fetch #(
    parameter int              MEM_AW    = 24,
    parameter logic [MEM_AW-1:0] BASE_ADDR = '0,
    parameter int              LINES     = 8
) (
    input logic                  clk,
    input logic                  reset,
    ga20_sample_fetch_if.slave   bus
);
    typedef enum logic {IDLE, FETCH} state_e;

    state_e            state_q, state_d;
    logic              sample_valid_q, sample_valid_d;
    logic [7:0]        sample_din_q, sample_din_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic              pend_q, pend_d;
    logic [19:0]       pend_addr_q, pend_addr_d;
    logic              super_q, super_d;
    logic              sel_q, sel_d;

    logic              req_active;
    logic [19:0]       req_addr;
    logic              hit;
    logic [15:0]       hit_word;
    logic              fill_en;

    function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic odd);
        return odd ? word[15:8] : word[7:0];
    endfunction

    // A fresh strobe takes priority over an older pending address.
    assign req_active = bus.sample_rd | pend_q;
    assign req_addr   = bus.sample_rd ? bus.sample_addr : pend_addr_q;
    assign fill_en    = (state_q == FETCH) && bus.mem_ack;

`ifdef GA20_FETCH_CACHE_EN
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 19 - IDX_W;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [15:0]       data_q [LINES];
    logic [18:0]       fill_word_q, fill_word_d;
    logic [IDX_W-1:0]  req_idx, fill_idx;
    logic [TAG_W-1:0]  req_tag;

    assign req_idx  = req_addr[IDX_W:1];
    assign req_tag  = req_addr[19:IDX_W+1];
    assign fill_idx = fill_word_q[IDX_W-1:0];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign hit_word = data_q[req_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= '0;
            fill_word_q <= '0;
        end else begin
            fill_word_q <= fill_word_d;
            if (fill_en) valid_q[fill_idx] <= 1'b1;
        end
    end

    // NOTE: tag/data storage has no reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_word_q[18:IDX_W];
            data_q[fill_idx] <= bus.mem_data;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_word = 16'h0000;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            sample_valid_q <= 1'b0;
            sample_din_q   <= 8'h00;
            mem_addr_q     <= '0;
            pend_q         <= 1'b0;
            pend_addr_q    <= '0;
            super_q        <= 1'b0;
            sel_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            sample_valid_q <= sample_valid_d;
            sample_din_q   <= sample_din_d;
            mem_addr_q     <= mem_addr_d;
            pend_q         <= pend_d;
            pend_addr_q    <= pend_addr_d;
            super_q        <= super_d;
            sel_q          <= sel_d;
        end
    end

    // NOTE: every always_comb output takes its hold value first, so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        sample_valid_d = sample_valid_q;
        sample_din_d   = sample_din_q;
        mem_addr_d     = mem_addr_q;
        pend_d         = pend_q;
        pend_addr_d    = pend_addr_q;
        super_d        = super_q;
        sel_d          = sel_q;
`ifdef GA20_FETCH_CACHE_EN
        fill_word_d    = fill_word_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_active) begin
                    pend_d = 1'b0;
                    if (hit) begin
                        sample_valid_d = 1'b1;
                        sample_din_d   = pick_byte(hit_word, req_addr[0]);
                    end else begin
                        sample_valid_d = 1'b0;
                        state_d        = FETCH;
                        mem_addr_d     = BASE_ADDR + MEM_AW'(req_addr[19:1]);
                        sel_d          = req_addr[0];
                        super_d        = 1'b0;
`ifdef GA20_FETCH_CACHE_EN
                        fill_word_d    = req_addr[19:1];
`endif
                    end
                end
            end
            FETCH: begin
                // A strobe during the fetch, even in the ack cycle, retires this fetch's answer.
                if (bus.sample_rd) begin
                    pend_d         = 1'b1;
                    pend_addr_d    = bus.sample_addr;
                    super_d        = 1'b1;
                    sample_valid_d = 1'b0;
                end
                if (bus.mem_ack) begin
                    state_d = IDLE;
                    if (!super_q && !bus.sample_rd) begin
                        sample_valid_d = 1'b1;
                        sample_din_d   = pick_byte(bus.mem_data, sel_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sample_valid = sample_valid_q;
    assign bus.sample_din   = sample_din_q;
    assign bus.mem_req      = (state_q == FETCH);
    assign bus.mem_addr     = mem_addr_q;
endmodule

// File: tb/tb_ga20_sample_fetch.sv
// Directed bench for ga20_sample_fetch: scoreboard of expected bytes, memory model on the req/ack port.
module tb_ga20_sample_fetch;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    ga20_sample_fetch_if #(.MEM_AW(24)) bus ();
    ga20_sample_fetch_if #(.MEM_AW(24)) wbus ();

    ga20_sample_fetch #(.MEM_AW(24), .BASE_ADDR(24'h000000), .LINES(8)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );
    ga20_sample_fetch #(.MEM_AW(24), .BASE_ADDR(24'hFFFFF0), .LINES(8)) dut_wrap (
        .clk(clk), .reset(reset), .bus(wbus.slave)
    );

    function automatic logic [15:0] mem_word(input logic [18:0] w);
        logic [7:0] lo;
        lo = w[7:0];
        if (w == 19'h8) return 16'hA55A;
        return {lo ^ 8'h96, lo ^ 8'h3C};
    endfunction

    function automatic logic [7:0] byte_at(input logic [19:0] addr);
        logic [15:0] w;
        w = mem_word(addr[19:1]);
        return addr[0] ? w[15:8] : w[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One-cycle strobe; returns at the negedge after the DUT sampled it.
    task automatic strobe(input logic [19:0] addr, input bit expect_out);
        bus.sample_rd   = 1'b1;
        bus.sample_addr = addr;
        if (expect_out) exp_q.push_back(byte_at(addr));
        @(negedge clk);
        bus.sample_rd = 1'b0;
    endtask

    // Memory model: waits (bounded) for mem_req, checks the address holds, then acks after lat cycles.
    task automatic serve(input string tag, input logic [23:0] exp_addr, input int lat);
        int n = 0;
        while (bus.mem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req"}, 32'(bus.mem_req), 32'd1);
        check({tag, "_addr"}, 32'(bus.mem_addr), 32'(exp_addr));
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check({tag, "_req_hold"}, 32'(bus.mem_req), 32'd1);
            check({tag, "_addr_hold"}, 32'(bus.mem_addr), 32'(exp_addr));
        end
        bus.mem_ack  = 1'b1;
        bus.mem_data = mem_word(exp_addr[18:0]);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check({tag, "_req_drop"}, 32'(bus.mem_req), 32'd0);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        check({tag, "_valid"}, 32'(bus.sample_valid), 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_din"}, 32'(bus.sample_din), 32'(e));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.sample_rd = 1'b0; bus.sample_addr = '0; bus.mem_ack = 1'b0; bus.mem_data = '0;
        wbus.sample_rd = 1'b0; wbus.sample_addr = '0; wbus.mem_ack = 1'b0; wbus.mem_data = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(bus.sample_valid), 32'd0);
        check("rst_din", 32'(bus.sample_din), 32'h00);
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Cold read: word 8, answer one cycle after the ack.
        strobe(20'h00010, 1'b1);
        check("cold_valid_low", 32'(bus.sample_valid), 32'd0);
        serve("cold", 24'h000008, 3);
        pop_check("cold");

        // Odd byte of the same word.
`ifdef GA20_FETCH_CACHE_EN
        strobe(20'h00011, 1'b1);
        check("hit_no_req", 32'(bus.mem_req), 32'd0);
        pop_check("hit");
`else
        strobe(20'h00011, 1'b1);
        check("refetch_valid_low", 32'(bus.sample_valid), 32'd0);
        serve("refetch", 24'h000008, 2);
        pop_check("refetch");
`endif

        repeat (3) @(negedge clk);
        check("hold_valid", 32'(bus.sample_valid), 32'd1);
        check("hold_din", 32'(bus.sample_din), 32'hA5);

        // Same index, new tag, then the evicted address again.
        strobe(20'h00020, 1'b1);
        serve("conflict", 24'h000010, 1);
        pop_check("conflict");
        strobe(20'h00010, 1'b1);
        check("evict_valid_low", 32'(bus.sample_valid), 32'd0);
        serve("evicted", 24'h000008, 2);
        pop_check("evicted");

        // Supersede: only the later address answers.
        strobe(20'h00100, 1'b0);
        strobe(20'h00102, 1'b1);
        serve("super_first", 24'h000080, 2);
        check("super_valid_low", 32'(bus.sample_valid), 32'd0);
        serve("super_second", 24'h000081, 2);
        pop_check("super");

        // Pending request that lands on the line just filled.
        strobe(20'h00200, 1'b0);
        strobe(20'h00201, 1'b1);
        serve("pend_fill", 24'h000100, 1);
        check("pend_valid_low", 32'(bus.sample_valid), 32'd0);
`ifdef GA20_FETCH_CACHE_EN
        @(negedge clk);
        check("pend_hit_no_req", 32'(bus.mem_req), 32'd0);
        pop_check("pend_hit");
`else
        serve("pend_refetch", 24'h000100, 1);
        pop_check("pend_refetch");
`endif

        // Reset in the middle of a fetch, then a stray ack.
        strobe(20'h00040, 1'b0);
        check("midrst_req_before", 32'(bus.mem_req), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_req_async", 32'(bus.mem_req), 32'd0);
        check("midrst_valid", 32'(bus.sample_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bus.mem_ack  = 1'b1;
        bus.mem_data = 16'hBEEF;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("late_ack_req", 32'(bus.mem_req), 32'd0);
        check("late_ack_valid", 32'(bus.sample_valid), 32'd0);
        @(negedge clk);
        check("late_ack_req2", 32'(bus.mem_req), 32'd0);
        strobe(20'h00010, 1'b1);
        check("post_rst_miss", 32'(bus.sample_valid), 32'd0);
        serve("post_rst", 24'h000008, 1);
        pop_check("post_rst");

        // Base offset wraps modulo 2^24.
        wbus.sample_rd   = 1'b1;
        wbus.sample_addr = 20'h00040;
        @(negedge clk);
        wbus.sample_rd = 1'b0;
        check("wrap_req", 32'(wbus.mem_req), 32'd1);
        check("wrap_addr", 32'(wbus.mem_addr), 32'h000010);
        wbus.mem_ack  = 1'b1;
        wbus.mem_data = 16'h1234;
        @(negedge clk);
        wbus.mem_ack = 1'b0;
        check("wrap_valid", 32'(wbus.sample_valid), 32'd1);
        check("wrap_din", 32'(wbus.sample_din), 32'h34);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
